fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//  Shares the single write port of the Async_fifo between N producers in the clk (write) domain.
//  Round-robin arbitration with burst lock: the grant holds while the owner keeps requesting, up to MAX_BURST beats, then rotates.
//  Drives the FIFO in/wr pins from registers, and throttles on full/fifo_cnt so the FIFO never overflows.
// PARAMETERS
//  N          4    number of requesters (2..8)
//  W          8    data width per requester; matches FIFO in/out width
//  DEPTH      64   FIFO depth in words
//  CNT_W      7    width of fifo_cnt input
//  MAX_BURST  4    max accepted beats per grant (1..15)
// PORTS
//  clk        in   1       write-domain clock
//  rst        in   1       asynchronous reset, active-high
//  req        in   N       per-requester valid; data on din slice is valid while high
//  din        in   N*W     flattened data, requester i on din[i*W +: W]
//  ack        out  N       combinational; beat accepted this cycle (grant[i] & req[i] & ~stall)
//  grant      out  N       registered one-hot owner, all-zero when idle
//  fifo_full  in   1       FIFO full flag (clk domain)
//  fifo_cnt   in   CNT_W   FIFO occupancy (clk domain)
//  fifo_wr    out  1       registered write enable to FIFO
//  fifo_din   out  W       registered write data to FIFO
//  busy       out  1       grant != 0
// BEHAVIOUR
//  Reset: grant=0, fifo_wr=0, fifo_din=0, ptr=0, beat_cnt=0, state=IDLE; ack=0 (grant=0).
//  stall = fifo_full | (fifo_wr & (fifo_cnt >= DEPTH-1)); this covers the write in flight in the output register.
//  Pick: first i with req[i], searching from ptr upward mod N.
//  IDLE: if any req, then grant<=onehot(pick), beat_cnt<=0, go to BURST; else stay. Arbitration latency is 1 cycle; no ack in IDLE.
//  BURST (owner o): ack[o] when req[o] & ~stall. On ack: fifo_wr<=1, fifo_din<=din[o], beat_cnt++.
//    Release when (ack & beat_cnt==MAX_BURST-1) or ~req[o]. On release: ptr<=(o+1)%N.
//    After release, re-pick in the same cycle with the updated ptr: BURST to the new owner, or IDLE if no req.
//    The owner can re-win only if no other req. There is no idle bubble between owners.
//  Stall during BURST holds the grant and does not count beats. A stalled owner keeps the grant until it drops req.
//  fifo_wr=0 on every cycle without an ack. Write latency is 1 clk from ack to fifo_wr.
//  Requesters must hold req/din until ack. Dropping req without ack is allowed and releases the grant.
//  grant is always one-hot or zero. ack is a subset of grant.
//  rst asserted mid-burst aborts immediately. An accepted beat not yet on fifo_wr is lost; producers resend after reset.
// CONFIGURATION
//  ARB_STATS_EN defined: adds out ports beats[N*16] and stalls[16]. Both clear on rst.
//    beats[i*16+:16] counts acks of requester i and wraps at 16'hFFFF.
//    stalls counts cycles with grant!=0 & req[owner] & stall, and saturates at 16'hFFFF.
//  ARB_STATS_EN undefined: those ports and counters are absent; all other behaviour is identical.
// TESTING
//  Single req[0]=1 with din0=a1,1b,ee,55,bf: grant=0001 at cycle 1.
//    Five fifo_wr pulses carry a1,1b,ee,55 then, after re-grant to 0, bf.
//  All req=1111, fifo never full: the grant order is 0,1,2,3,0, each for 4 beats.
//    fifo_wr is continuous after the first grant.
//  fifo_cnt=63 with a write in flight: ack=0 next cycle. fifo_full=1 holds stall.
//    Deassert: writes resume and no word is lost or duplicated.
//  Owner 2 drops req after 2 beats while req1,req3 are high: the next grant is 3 (ptr=3), with no gap cycle.
//  rst pulse mid-burst: grant, fifo_wr and busy go 0 asynchronously; after release the first grant goes to req0 (ptr=0).
//  With ARB_STATS_EN: after the scenario-2 run of 32 beats, beats[i]=8 for each i and stalls=0.

Source files
------------

// File: rtl/fifo_wr_arbiter_if.sv
// Write-port bundle between producers, the arbiter and the async FIFO.
// master: producer/FIFO side; slave: the arbiter.
interface fifo_wr_arbiter_if #(
    parameter int N     = 4,
    parameter int W     = 8,
    parameter int CNT_W = 7
);
    logic [N-1:0]     req;
    logic [N*W-1:0]   din;
    logic [N-1:0]     ack;
    logic [N-1:0]     grant;
    logic             fifo_full;
    logic [CNT_W-1:0] fifo_cnt;
    logic             fifo_wr;
    logic [W-1:0]     fifo_din;
    logic             busy;

    modport master (
        output req, din, fifo_full, fifo_cnt,
        input  ack, grant, fifo_wr, fifo_din, busy
    );

    modport slave (
        input  req, din, fifo_full, fifo_cnt,
        output ack, grant, fifo_wr, fifo_din, busy
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst-locked arbiter for the async FIFO write port.
// Define ARB_STATS_EN to add per-requester beat and stall counters.
module fifo_wr_arbiter #(
    parameter int N         = 4,
    parameter int W         = 8,
    parameter int DEPTH     = 64,
    parameter int CNT_W     = 7,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    fifo_wr_arbiter_if.slave bus
`ifdef ARB_STATS_EN
    ,
    output logic [N*16-1:0]  beats,
    output logic [15:0]      stalls
`endif
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {IDLE, BURST} state_e;

    state_e         state_q, state_d;
    logic [N-1:0]   grant_q, grant_d;
    logic [PW-1:0]  ptr_q, ptr_d;
    logic [3:0]     beat_q, beat_d;
    logic           wr_q, wr_d;
    logic [W-1:0]   wdat_q, wdat_d;

    logic [PW-1:0]  owner;
    logic [PW-1:0]  ptr_nxt;
    logic           own_req;
    logic           stall;
    logic           accept;
    logic           rel;

    // First requester at or above p, wrapping modulo N.
    function automatic logic [PW-1:0] pick(input logic [N-1:0] r,
                                           input logic [PW-1:0] p);
        logic [PW-1:0] sel;
        logic          found;
        int            idx;
        sel   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(p) + k) % N;
            if (!found && r[idx]) begin
                sel   = PW'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    // Binary index of the one-hot owner.
    always_comb begin
        owner = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_q[i]) owner = PW'(i);
        end
    end

    // The in-flight write in the output register counts towards occupancy.
    assign stall   = bus.fifo_full |
                     (wr_q & (bus.fifo_cnt >= CNT_W'(DEPTH - 1)));
    assign own_req = bus.req[owner];
    assign accept  = (state_q == BURST) & own_req & ~stall;
    assign rel     = (accept & (beat_q == 4'(MAX_BURST - 1))) | ~own_req;
    assign ptr_nxt = (int'(owner) == N - 1) ? '0 : PW'(int'(owner) + 1);

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            beat_q  <= '0;
            wr_q    <= 1'b0;
            wdat_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            beat_q  <= beat_d;
            wr_q    <= wr_d;
            wdat_q  <= wdat_d;
        end
    end

    // Next state: grant, burst counting and same-cycle handover.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        beat_d  = beat_q;
        wr_d    = 1'b0;
        wdat_d  = wdat_q;
        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    grant_d = N'(1) << pick(bus.req, ptr_q);
                    beat_d  = '0;
                    state_d = BURST;
                end
            end
            BURST: begin
                if (accept) begin
                    wr_d   = 1'b1;
                    wdat_d = bus.din[int'(owner)*W +: W];
                    beat_d = beat_q + 4'd1;
                end
                if (rel) begin
                    ptr_d  = ptr_nxt;
                    beat_d = '0;
                    if (|bus.req) begin
                        grant_d = N'(1) << pick(bus.req, ptr_nxt);
                        state_d = BURST;
                    end else begin
                        grant_d = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: ;
        endcase
    end

    // Outputs: combinational ack, registered FIFO pins.
    always_comb begin
        bus.ack = '0;
        if (accept) bus.ack = grant_q;
    end

    assign bus.grant    = grant_q;
    assign bus.fifo_wr  = wr_q;
    assign bus.fifo_din = wdat_q;
    assign bus.busy     = |grant_q;

`ifdef ARB_STATS_EN
    logic [N-1:0][15:0] beats_q;
    logic [15:0]        stalls_q;

    // Per-requester ack counters wrap; the stall counter saturates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beats_q  <= '0;
            stalls_q <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (bus.ack[i]) beats_q[i] <= beats_q[i] + 16'd1;
            end
            if ((|grant_q) & own_req & stall & (stalls_q != 16'hFFFF))
                stalls_q <= stalls_q + 16'd1;
        end
    end

    assign beats  = beats_q;
    assign stalls = stalls_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter.
// Producers are modelled as per-requester word queues.
module tb_fifo_wr_arbiter;

    localparam int N     = 4;
    localparam int W     = 8;
    localparam int CNT_W = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fifo_wr_arbiter_if #(.N(N), .W(W), .CNT_W(CNT_W)) bus ();

`ifdef ARB_STATS_EN
    logic [N*16-1:0] beats;
    logic [15:0]     stalls;
`endif

    fifo_wr_arbiter #(
        .N(N), .W(W), .DEPTH(64), .CNT_W(CNT_W), .MAX_BURST(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef ARB_STATS_EN
        ,
        .beats(beats),
        .stalls(stalls)
`endif
    );

    always #5 clk = ~clk;

    int         tests  = 0;
    int         failed = 0;
    int         ncyc;
    logic [7:0] pq[N][$];
    logic [N-1:0] en;
    logic [7:0] got_q[$];
    logic [7:0] ew[$];
    int         own_q[$];
    int         eo[$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bus.req[i] = en[i] && (pq[i].size() > 0);
            bus.din[i*W +: W] = (pq[i].size() > 0) ? pq[i][0] : 8'h00;
        end
    endtask

    function automatic int left();
        int s = 0;
        for (int i = 0; i < N; i++) if (en[i]) s += pq[i].size();
        return s;
    endfunction

    // One clock: sample ack just before the edge, capture fifo output after.
    task automatic cyc();
        logic [N-1:0] a;
        drive();
        while (($time % 10) != 4) #1;
        a = bus.ack;
        for (int i = 0; i < N; i++) begin
            if (a[i]) begin
                pq[i].delete(0);
                own_q.push_back(i);
            end
        end
        @(posedge clk);
        #1;
        if (bus.fifo_wr === 1'b1) got_q.push_back(bus.fifo_din);
        @(negedge clk);
        drive();
        ncyc++;
    endtask

    task automatic drain(input string tag);
        int lim = 60;
        while (left() > 0 && lim > 0) begin
            cyc();
            lim--;
        end
        chk({tag, "_drained"}, left(), 0);
    endtask

    task automatic chk_words(input string tag);
        chk({tag, "_count"}, got_q.size(), ew.size());
        for (int k = 0; k < ew.size() && k < got_q.size(); k++)
            chk($sformatf("%s[%0d]", tag, k), got_q[k], ew[k]);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < N; i++) pq[i].delete();
        en = '0;
        drive();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        got_q.delete();
        own_q.delete();
    endtask

    initial begin
        bus.fifo_full = 1'b0;
        bus.fifo_cnt  = '0;
        en = '0;
        drive();
        @(negedge clk);
        chk("rst_grant", bus.grant, 0);
        chk("rst_wr", bus.fifo_wr, 0);
        chk("rst_din", bus.fifo_din, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_ack", bus.ack, 0);
        rst = 1'b0;

        // Single requester, five words: burst of 4 then re-grant.
        en = 4'b0001;
        pq[0] = '{8'ha1, 8'h1b, 8'hee, 8'h55, 8'hbf};
        ncyc = 0;
        cyc();
        chk("s1_grant", bus.grant, 4'b0001);
        drain("s1");
        chk("s1_cycles", ncyc, 6);
        cyc();
        chk("s1_idle_grant", bus.grant, 0);
        chk("s1_idle_busy", bus.busy, 0);
        ew = '{8'ha1, 8'h1b, 8'hee, 8'h55, 8'hbf};
        chk_words("s1_data");

        // All four requesting, FIFO never full.
        do_reset();
        en = 4'b1111;
        for (int i = 0; i < N; i++)
            for (int k = 0; k < 8; k++) pq[i].push_back(8'(i*16 + k));
        ncyc = 0;
        cyc();
        chk("s2_grant", bus.grant, 4'b0001);
        drain("s2");
        chk("s2_cycles", ncyc, 33);
        chk("s2_nacks", own_q.size(), 32);
        ew.delete();
        for (int b = 0; b < 32; b++) begin
            ew.push_back(8'((((b / 4) % 4) * 16) + ((b / 16) * 4) + (b % 4)));
            if (b < own_q.size())
                chk($sformatf("s2_owner[%0d]", b), own_q[b], (b / 4) % 4);
        end
        chk_words("s2_data");
`ifdef ARB_STATS_EN
        for (int i = 0; i < N; i++)
            chk($sformatf("s2_beats[%0d]", i), beats[i*16 +: 16], 8);
        chk("s2_stalls", stalls, 0);
`endif

        // Throttling on fifo_cnt and fifo_full.
        do_reset();
        en = 4'b0001;
        pq[0] = '{8'h10, 8'h11, 8'h12, 8'h13};
        bus.fifo_cnt = 7'd62;
        cyc();
        cyc();
        chk("s3_wr_first", bus.fifo_wr, 1);
        bus.fifo_cnt = 7'd63;
        #1;
        chk("s3_ack_cnt63", bus.ack, 0);
        cyc();
        chk("s3_wr_gap", bus.fifo_wr, 0);
        chk("s3_grant_hold", bus.grant, 4'b0001);
        bus.fifo_full = 1'b1;
        #1;
        chk("s3_ack_full", bus.ack, 0);
        for (int c = 0; c < 3; c++) begin
            cyc();
            chk($sformatf("s3_full_wr[%0d]", c), bus.fifo_wr, 0);
            chk($sformatf("s3_full_grant[%0d]", c), bus.grant, 4'b0001);
        end
        bus.fifo_full = 1'b0;
        bus.fifo_cnt  = 7'd10;
        drain("s3");
        cyc();
        ew = '{8'h10, 8'h11, 8'h12, 8'h13};
        chk_words("s3_data");
`ifdef ARB_STATS_EN
        chk("s3_beats0", beats[15:0], 4);
        chk("s3_stalls", stalls, 4);
`endif

        // Owner 2 drops early; handover to 3 then 1 without a gap.
        do_reset();
        bus.fifo_cnt = '0;
        en = 4'b0100;
        pq[2] = '{8'h20, 8'h21};
        cyc();
        chk("s4_grant2", bus.grant, 4'b0100);
        en = 4'b1110;
        pq[1] = '{8'h31};
        pq[3] = '{8'h41};
        cyc();
        cyc();
        cyc();
        chk("s4_grant3", bus.grant, 4'b1000);
        #1;
        chk("s4_ack3", bus.ack, 4'b1000);
        cyc();
        cyc();
        chk("s4_grant1", bus.grant, 4'b0010);
        cyc();
        eo = '{2, 2, 3, 1};
        chk("s4_nacks", own_q.size(), 4);
        for (int k = 0; k < 4 && k < own_q.size(); k++)
            chk($sformatf("s4_owner[%0d]", k), own_q[k], eo[k]);
        ew = '{8'h20, 8'h21, 8'h41, 8'h31};
        chk_words("s4_data");
        cyc();
        chk("s4_idle", bus.grant, 0);

        // Reset mid-burst of owner 3; pointer returns to 0.
        en = 4'b1000;
        pq[3] = '{8'h50, 8'h51, 8'h52, 8'h53};
        cyc();
        chk("s5_grant3", bus.grant, 4'b1000);
        cyc();
        chk("s5_wr", bus.fifo_wr, 1);
        rst = 1'b1;
        #1;
        chk("s5_rst_grant", bus.grant, 0);
        chk("s5_rst_wr", bus.fifo_wr, 0);
        chk("s5_rst_busy", bus.busy, 0);
        for (int i = 0; i < N; i++) pq[i].delete();
        en = '0;
        drive();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        en = 4'b1111;
        for (int i = 0; i < N; i++) pq[i] = '{8'(8'h60 + i)};
        cyc();
        chk("s5_regrant", bus.grant, 4'b0001);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
